// File: rtl/butterfly_pair_sequencer.sv
// butterfly_pair_sequencer: buffers one frame of complex samples, then issues the
// DIT butterfly operand pairs of one stage together with their twiddle factors.
module butterfly_pair_sequencer #(
   parameter int n     = 32,
   parameter int d     = 16,
   parameter int size  = 8,
   parameter int stage = 0,
   localparam int aw   = (size > 2) ? $clog2(size / 2) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          recv_val,
   output logic          recv_rdy,
   input  logic [n-1:0]  recv_r,
   input  logic [n-1:0]  recv_c,
   output logic          send_val,
   input  logic          send_rdy,
   output logic [n-1:0]  ar,
   output logic [n-1:0]  ac,
   output logic [n-1:0]  br,
   output logic [n-1:0]  bc,
   output logic [n-1:0]  wr,
   output logic [n-1:0]  wc,
   output logic [aw-1:0] tw_addr,
   input  logic [n-1:0]  tw_r,
   input  logic [n-1:0]  tw_c,
   output logic          last
);
   localparam int lw     = $clog2(size);
   localparam int span   = 1 << stage;
   localparam int twstep = size / (2 * span);

   if (size < 2 || (size & (size - 1)) != 0 || stage >= lw || d >= n) begin : g_bad_cfg
      $error("butterfly_pair_sequencer: illegal parameter set");
   end

   typedef enum logic {LOAD, ISSUE} state_e;

   state_e            state_q, state_d;
   logic [lw-1:0]     ptr_q, ptr_d;
   logic [aw-1:0]     p_q, p_d;
   logic [2*n-1:0]    buf_q [size];
   logic [lw-1:0]     ia, ib;
   logic [2*n-1:0]    a, b;
   logic              issue;

   always_comb begin
      issue    = state_q == ISSUE;
      recv_rdy = reset && !issue;
      send_val = issue;
      // i inserts a zero bit at position stage into p; j sets that bit
      ia       = lw'(((int'(p_q) >> stage) << (stage + 1)) | (int'(p_q) & (span - 1)));
      ib       = ia + lw'(span);
      a        = buf_q[ia];
      b        = buf_q[ib];
      {ar, ac} = issue ? a : '0;
      {br, bc} = issue ? b : '0;
      tw_addr  = issue ? aw'((int'(p_q) & (span - 1)) * twstep) : '0;
      wr       = issue ? tw_r : '0;
      wc       = issue ? tw_c : '0;
      last     = issue && p_q == aw'(size / 2 - 1);
      ptr_d    = ptr_q;
      p_d      = p_q;
      state_d  = state_q;
      if (!issue && recv_val) begin
         ptr_d   = (ptr_q == lw'(size - 1)) ? '0 : ptr_q + 1'b1;
         state_d = (ptr_q == lw'(size - 1)) ? ISSUE : LOAD;
      end
      if (issue && send_rdy) begin
         p_d     = last ? '0 : p_q + 1'b1;
         state_d = last ? LOAD : ISSUE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LOAD;
         ptr_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         p_q     <= p_d;
      end
   end

   // sample storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (!issue && recv_val) buf_q[ptr_q] <= {recv_r, recv_c};
   end
endmodule

// File: tb/tb_butterfly_pair_sequencer.sv
// tb_butterfly_pair_sequencer: runs stages 0..2 of an 8-point sequencer in lockstep
// against a frame-level model of the expected pair order and twiddle addresses.
module tb_butterfly_pair_sequencer;
   logic        clk = 0;
   logic        reset = 0;
   logic        recv_val = 0;
   logic        send_rdy = 1;
   logic [31:0] recv_r = 0;
   logic [31:0] recv_c = 0;
   logic        recv_rdy [3];
   logic        send_val [3];
   logic        last [3];
   logic [31:0] ar [3], ac [3], br [3], bc [3], wr [3], wc [3], tw_r [3], tw_c [3];
   logic [1:0]  tw_addr [3];

   int checks = 0;
   int passes = 0;
   logic [31:0] mr [8];
   logic [31:0] mc [8];
   bit m_issue = 0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] tr(int s, int a);
      return 32'hA000_0000 + 32'(s * 256 + a * 17);
   endfunction

   function automatic logic [31:0] tc(int s, int a);
      return 32'h5000_0000 ^ 32'(s * 4096 + a * 3 + 1);
   endfunction

   // p-th pair of stage s: ascending i whose bit s is clear
   function automatic int pair_i(int s, int p);
      int k = 0;
      for (int i = 0; i < 8; i++) begin
         if (((i >> s) & 1) == 0) begin
            if (k == p) return i;
            k++;
         end
      end
      return 0;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign tw_r[g] = tr(g, int'(tw_addr[g]));
      assign tw_c[g] = tc(g, int'(tw_addr[g]));
      butterfly_pair_sequencer #(.n(32), .d(16), .size(8), .stage(g)) u_dut (
         .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy[g]),
         .recv_r(recv_r), .recv_c(recv_c), .send_val(send_val[g]), .send_rdy(send_rdy),
         .ar(ar[g]), .ac(ac[g]), .br(br[g]), .bc(bc[g]), .wr(wr[g]), .wc(wc[g]),
         .tw_addr(tw_addr[g]), .tw_r(tw_r[g]), .tw_c(tw_c[g]), .last(last[g])
      );
   end

   task automatic chk(string name, int s, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s stage%0d: got %h expected %h at %0t", name, s, act, exp, $time);
   endtask

   always @(negedge clk) begin
      for (int s = 0; s < 3; s++) begin
         if (!reset) begin
            chk("rst_recv_rdy", s, 32'(recv_rdy[s]), 0);
            chk("rst_send_val", s, 32'(send_val[s]), 0);
            chk("rst_last", s, 32'(last[s]), 0);
            chk("rst_tw_addr", s, 32'(tw_addr[s]), 0);
            chk("rst_ar", s, ar[s], 0);
         end else if (!m_issue) begin
            chk("load_recv_rdy", s, 32'(recv_rdy[s]), 1);
            chk("load_send_val", s, 32'(send_val[s]), 0);
            chk("load_last", s, 32'(last[s]), 0);
            chk("load_zero_data", s, ar[s] | ac[s] | br[s] | bc[s] | wr[s] | wc[s], 0);
         end else begin
            int ei, ej, tw;
            ei = pair_i(s, m_cnt);
            ej = ei + (1 << s);
            tw = (ei % (1 << s)) * (8 >> (s + 1));
            chk("issue_recv_rdy", s, 32'(recv_rdy[s]), 0);
            chk("issue_send_val", s, 32'(send_val[s]), 1);
            chk("ar", s, ar[s], mr[ei]);
            chk("ac", s, ac[s], mc[ei]);
            chk("br", s, br[s], mr[ej]);
            chk("bc", s, bc[s], mc[ej]);
            chk("tw_addr", s, 32'(tw_addr[s]), 32'(tw));
            chk("wr", s, wr[s], tr(s, tw));
            chk("wc", s, wc[s], tc(s, tw));
            chk("last", s, 32'(last[s]), 32'(m_cnt == 3));
         end
      end
      if (!reset) begin
         m_issue = 0;
         m_cnt = 0;
      end else if (!m_issue) begin
         if (recv_val) begin
            mr[m_cnt] = recv_r;
            mc[m_cnt] = recv_c;
            m_cnt++;
            if (m_cnt == 8) begin
               m_issue = 1;
               m_cnt = 0;
            end
         end
      end else if (send_rdy) begin
         m_cnt++;
         if (m_cnt == 4) begin
            m_issue = 0;
            m_cnt = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(int base, bit rnd);
      for (int k = 0; k < 8; k++) begin
         recv_val = 1;
         recv_r = rnd ? $urandom : 32'(base + k);
         recv_c = rnd ? $urandom : 32'(base + 100 + k);
         step();
      end
      recv_val = 0;
   endtask

   initial begin
      repeat (3) step();
      reset = 1;
      load_frame(0, 0);
      @(negedge clk);
      chk("lit_p0_sv", 0, 32'(send_val[0]), 1);
      chk("lit_p0_ar", 0, ar[0], 0);
      chk("lit_p0_br", 0, br[0], 1);
      chk("lit_p0_br", 2, br[2], 4);
      chk("lit_p0_bc", 2, bc[2], 104);
      step();
      @(negedge clk);
      chk("lit_p1_ar", 0, ar[0], 2);
      chk("lit_p1_br", 0, br[0], 3);
      chk("lit_p1_ar", 1, ar[1], 1);
      chk("lit_p1_br", 1, br[1], 3);
      chk("lit_p1_tw", 1, 32'(tw_addr[1]), 2);
      chk("lit_p1_wr", 1, wr[1], 32'hA000_0122);
      chk("lit_p1_br", 2, br[2], 5);
      chk("lit_p1_tw", 2, 32'(tw_addr[2]), 1);
      step();
      @(negedge clk);
      chk("lit_p2_last", 0, 32'(last[0]), 0);
      step();
      @(negedge clk);
      chk("lit_p3_last", 0, 32'(last[0]), 1);
      chk("lit_p3_ar", 2, ar[2], 3);
      chk("lit_p3_bc", 2, bc[2], 107);
      step();
      @(negedge clk);
      chk("lit_reload_rdy", 0, 32'(recv_rdy[0]), 1);
      begin
         int cnt = 0;
         for (int c = 0; c < 40 && cnt < 8; c++) begin
            recv_val = (c % 2) == 0;
            recv_r = $urandom;
            recv_c = $urandom;
            if (recv_val) cnt++;
            step();
         end
         recv_val = 0;
      end
      @(negedge clk);
      chk("toggle_issue", 0, 32'(send_val[0]), 1);
      step();
      send_rdy = 0;
      repeat (3) step();
      send_rdy = 1;
      repeat (4) step();
      load_frame(0, 1);
      step();
      reset = 0;
      @(negedge clk);
      chk("mid_rst_sv", 1, 32'(send_val[1]), 0);
      step();
      reset = 1;
      load_frame(50, 0);
      repeat (6) step();
      for (int c = 0; c < 600; c++) begin
         recv_val = $urandom_range(0, 3) != 0;
         send_rdy = $urandom_range(0, 3) != 0;
         recv_r = $urandom;
         recv_c = $urandom;
         reset = $urandom_range(0, 99) != 0;
         step();
      end
      reset = 1;
      repeat (3) step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/butterfly_pair_sequencer.md
Name: butterfly_pair_sequencer

Overview:
Upstream feeder for the butterfly unit in one FFT stage. It collects one frame of `size` complex samples over a val/rdy stream into an internal buffer. It then issues the size/2 butterfly operand pairs (a, b) for the configured stage, each with its twiddle factor w. Twiddles are fetched from an external table through an address port. The output side connects directly to the butterfly unit's recv_val/recv_rdy/ar/ac/br/bc/wr/wc inputs.

Parameters:
n, 32, total fixed-point word width of each real/imag component
d, 16, fractional bits (pass-through only; no arithmetic performed here)
size, 8, frame length in points; power of 2, >= 2
stage, 0, FFT stage index (DIT); span = 2^stage; legal range 0 .. log2(size)-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
recv_val  input  1  input sample valid
recv_rdy  output  1  sequencer can accept a sample
recv_r  input  n  input sample, real part
recv_c  input  n  input sample, imaginary part
send_val  output  1  operand pair valid toward the butterfly
send_rdy  input  1  butterfly accepts the pair
ar, ac  output  n  operand a (real, imag)
br, bc  output  n  operand b (real, imag)
wr, wc  output  n  twiddle (real, imag), passed from tw_r/tw_c
tw_addr  output  max(1,clog2(size/2))  twiddle table index
tw_r, tw_c  input  n  twiddle table data; combinational, valid in the same cycle as tw_addr
last  output  1  high with the final pair of a frame

Behaviour:
- Reset (reset=0, async): state=LOAD, load pointer=0, pair index p=0.
  - send_val=0, last=0, tw_addr=0.
  - recv_rdy=0 while reset is held.
  - Buffer contents are not reset.
- Data outputs: ar/ac/br/bc/wr/wc are forced to 0 whenever send_val=0.
- LOAD state:
  - recv_rdy=1, send_val=0.
  - On recv_val&&recv_rdy: buf[ptr] <= {recv_r, recv_c}; ptr increments.
  - On the accept where ptr==size-1: ptr wraps to 0 and the next state is ISSUE.
  - recv_val=0 cycles stall with no state change.
- ISSUE state:
  - recv_rdy=0, send_val=1.
  - Pair p is presented combinationally from registered state:
    - blk = p / span, off = p mod span
    - i = blk*2*span + off, j = i + span
    - a = buf[i], b = buf[j]
    - tw_addr = off * (size/(2*span)), w = {tw_r, tw_c}
    - last = (p == size/2-1)
  - On send_val&&send_rdy: p increments. If p was size/2-1, then p <= 0 and the next state is LOAD.
  - With send_rdy=0, all outputs hold stable (p is unchanged).
- Timing:
  - First send_val is in the cycle after the size-th accept.
  - Minimum frame period = size + size/2 cycles.
  - There is no load/issue overlap (single buffer).
- Reset asserted mid-LOAD or mid-ISSUE: the partial frame is discarded. After release, the block is in LOAD with ptr=0, p=0, and the next accepted sample is element 0.
- No arithmetic and no width conversion: all values pass through bit-exact.

Test Plan:
- size=8, stage=0, samples k -> (r=k, c=100+k), send_rdy=1 -> pairs (0,1),(2,3),(4,5),(6,7); tw_addr 0,0,0,0; last only on the 4th pair; recv_rdy returns to 1 after the 4th pair.
- size=8, stage=1, same frame -> pairs (0,2),(1,3),(4,6),(5,7); tw_addr 0,2,0,2; wr/wc equal the table data driven for each address.
- size=8, stage=2 -> pairs (0,4),(1,5),(2,6),(3,7); tw_addr 0,1,2,3; first send_val exactly 1 cycle after the 8th accept.
- Backpressure: send_rdy low for 3 cycles on pair 1 -> ar/ac/br/bc/wr/wc/tw_addr held constant; recv_rdy stays 0; no pair skipped or duplicated.
- recv_val toggled 1/0 every cycle during LOAD -> exactly 8 accepts stored in order; issue begins after the 8th accept.
- reset pulsed low during the 2nd issued pair -> send_val=0 and recv_rdy=0 immediately; after release recv_rdy=1; a new frame of 8 samples issues from pair (i=0) correctly.
